// File: rtl/mby_egr_pod_injector.sv
// Egress dirty-pod injector: queues freed pod pointers and drops them into empty ring slots.
// Optional MBY_POD_INJ_STATS_EN adds saturating injection / stall-cycle counters.
module mby_egr_pod_injector #(
    parameter int PTR_W    = 14,
    parameter int DEPTH    = 16,
    parameter int HI_WM    = 12,
    parameter int STARVE_C = 255
) (
    input  logic             cclk,
    input  logic             reset_n,
    input  logic             pod_free_valid,
    input  logic [PTR_W-1:0] pod_free_ptr,
    output logic             pod_free_ready,
    input  logic             pod_ring_in_valid,
    input  logic [PTR_W-1:0] pod_ring_in_ptr,
    input  logic             pod_ring_stall_in,
    output logic             pod_ring_out_valid,
    output logic [PTR_W-1:0] pod_ring_out_ptr,
    output logic             pod_fifo_hi,
    output logic             pod_starve
`ifdef MBY_POD_INJ_STATS_EN
    ,
    output logic [31:0]      pod_inj_cnt,
    output logic [31:0]      pod_stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_C + 1);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   HI_LVL   = (AW+1)'(HI_WM);
    localparam logic [SW-1:0] STV      = SW'(STARVE_C);

    typedef enum logic [1:0] {IDLE, INJ, STALL} state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count, count_nxt;
    logic             push, pop, full, empty;
    logic [SW-1:0]    starve_cnt, starve_cnt_nxt;
    logic             starve_inc, starve_clr;

    assign full           = (count == FULL_LVL);
    assign empty          = (count == '0);
    assign pod_free_ready = reset_n & ~full;
    assign push           = pod_free_valid & pod_free_ready;
    // Inject only into an empty slot while GPM is not stalling.
    assign pop            = ~pod_ring_in_valid & ~pod_ring_stall_in & ~empty;
    assign count_nxt      = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    always_ff @(posedge cclk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    always_ff @(posedge cclk) begin
        if (push) mem[wr_ptr] <= pod_free_ptr;
    end

    always_ff @(posedge cclk) begin
        if (!reset_n) begin
            pod_ring_out_valid <= 1'b0;
            pod_ring_out_ptr   <= '0;
        end else if (pod_ring_in_valid) begin
            pod_ring_out_valid <= 1'b1;
            pod_ring_out_ptr   <= pod_ring_in_ptr;
        end else if (pop) begin
            pod_ring_out_valid <= 1'b1;
            pod_ring_out_ptr   <= mem[rd_ptr];
        end else begin
            pod_ring_out_valid <= 1'b0;
            pod_ring_out_ptr   <= '0;
        end
    end

    always_ff @(posedge cclk) begin
        if (!reset_n) pod_fifo_hi <= 1'b0;
        else          pod_fifo_hi <= (count_nxt >= HI_LVL);
    end

    always_ff @(posedge cclk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (push) state_nxt = INJ;
            INJ: begin
                if (pod_ring_stall_in)     state_nxt = STALL;
                else if (count_nxt == '0)  state_nxt = IDLE;
            end
            STALL: begin
                if (!pod_ring_stall_in)
                    state_nxt = (count_nxt == '0) ? IDLE : INJ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Starvation only accrues while injecting is allowed but the ring stays full.
    always_comb begin
        starve_inc = 1'b0;
        starve_clr = pop;
        unique case (state)
            IDLE:    starve_clr = 1'b1;
            INJ:     starve_inc = ~pop & ~pod_ring_stall_in;
            STALL:   starve_inc = 1'b0;
            default: starve_clr = 1'b1;
        endcase
    end

    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (starve_clr)
            starve_cnt_nxt = '0;
        else if (starve_inc && starve_cnt != STV)
            starve_cnt_nxt = starve_cnt + 1'b1;
    end

    always_ff @(posedge cclk) begin
        if (!reset_n) begin
            starve_cnt <= '0;
            pod_starve <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
            if (pop)
                pod_starve <= 1'b0;
            else if (starve_cnt_nxt == STV)
                pod_starve <= 1'b1;
        end
    end

`ifdef MBY_POD_INJ_STATS_EN
    always_ff @(posedge cclk) begin
        if (!reset_n) begin
            pod_inj_cnt   <= '0;
            pod_stall_cnt <= '0;
        end else begin
            if (pop && pod_inj_cnt != '1)
                pod_inj_cnt <= pod_inj_cnt + 1'b1;
            if (pod_ring_stall_in && !empty && pod_stall_cnt != '1)
                pod_stall_cnt <= pod_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mby_egr_pod_injector.sv
// Scoreboard bench for mby_egr_pod_injector: a reference FIFO model predicts
// every ring slot; a negedge monitor pops and compares pointer and cycle.
module tb_mby_egr_pod_injector;

    localparam int PTR_W = 14;
    localparam int DEPTH = 16;

    logic             cclk = 1'b0;
    logic             reset_n;
    logic             pod_free_valid;
    logic [PTR_W-1:0] pod_free_ptr;
    logic             pod_free_ready;
    logic             pod_ring_in_valid;
    logic [PTR_W-1:0] pod_ring_in_ptr;
    logic             pod_ring_stall_in;
    logic             pod_ring_out_valid;
    logic [PTR_W-1:0] pod_ring_out_ptr;
    logic             pod_fifo_hi;
    logic             pod_starve;
`ifdef MBY_POD_INJ_STATS_EN
    logic [31:0]      pod_inj_cnt;
    logic [31:0]      pod_stall_cnt;
`endif

    mby_egr_pod_injector dut (
        .cclk               (cclk),
        .reset_n            (reset_n),
        .pod_free_valid     (pod_free_valid),
        .pod_free_ptr       (pod_free_ptr),
        .pod_free_ready     (pod_free_ready),
        .pod_ring_in_valid  (pod_ring_in_valid),
        .pod_ring_in_ptr    (pod_ring_in_ptr),
        .pod_ring_stall_in  (pod_ring_stall_in),
        .pod_ring_out_valid (pod_ring_out_valid),
        .pod_ring_out_ptr   (pod_ring_out_ptr),
        .pod_fifo_hi        (pod_fifo_hi),
        .pod_starve         (pod_starve)
`ifdef MBY_POD_INJ_STATS_EN
        ,
        .pod_inj_cnt        (pod_inj_cnt),
        .pod_stall_cnt      (pod_stall_cnt)
`endif
    );

    always #5 cclk = ~cclk;

    typedef struct {
        logic [PTR_W-1:0] ptr;
        int               cyc;
    } exp_t;

    exp_t             exp_q[$];
    logic [PTR_W-1:0] mq[$];
    int               vec = 0;
    int               errs = 0;
    int               cyc = 0;
    logic             mon_en = 1'b0;

    always @(posedge cclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vec++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive one cycle; the model predicts what the ring carries after the edge.
    task automatic step(input logic fv, input logic [PTR_W-1:0] fp,
                        input logic iv, input logic [PTR_W-1:0] ip,
                        input logic st);
        exp_t e;
        int   n;
        n = mq.size();
        pod_free_valid    = fv;
        pod_free_ptr      = fp;
        pod_ring_in_valid = iv;
        pod_ring_in_ptr   = ip;
        pod_ring_stall_in = st;
        chk("free_ready", {31'b0, pod_free_ready}, {31'b0, n < DEPTH});
        if (iv) begin
            e.ptr = ip;
            e.cyc = cyc + 1;
            exp_q.push_back(e);
        end else if (!st && n > 0) begin
            e.ptr = mq.pop_front();
            e.cyc = cyc + 1;
            exp_q.push_back(e);
        end
        if (fv && n < DEPTH) mq.push_back(fp);
        @(posedge cclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        reset_n           = 1'b0;
        pod_free_valid    = 1'b0;
        pod_free_ptr      = '0;
        pod_ring_in_valid = 1'b0;
        pod_ring_in_ptr   = '0;
        pod_ring_stall_in = 1'b0;
        mq.delete();
        exp_q.delete();
        @(posedge cclk);
        #1;
        @(posedge cclk);
        #1;
        chk("rst_out_valid", {31'b0, pod_ring_out_valid}, 32'd0);
        chk("rst_out_ptr", {18'b0, pod_ring_out_ptr}, 32'd0);
        chk("rst_fifo_hi", {31'b0, pod_fifo_hi}, 32'd0);
        chk("rst_starve", {31'b0, pod_starve}, 32'd0);
        chk("rst_ready_low", {31'b0, pod_free_ready}, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("ready_after_rst", {31'b0, pod_free_ready}, 32'd1);
    endtask

    always @(negedge cclk) begin
        exp_t e;
        if (mon_en) begin
            if (pod_ring_out_valid) begin
                if (exp_q.size() == 0) begin
                    vec++;
                    errs++;
                    $display("FAIL ring_unexpected: got ptr %0h, required no slot", pod_ring_out_ptr);
                end else begin
                    e = exp_q.pop_front();
                    chk("ring_ptr", {18'b0, pod_ring_out_ptr}, {18'b0, e.ptr});
                    chk("ring_cycle", cyc, e.cyc);
                end
            end else begin
                chk("empty_slot_ptr", {18'b0, pod_ring_out_ptr}, 32'd0);
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    vec++;
                    errs++;
                    $display("FAIL ring_missing: got no slot, required ptr %0h", e.ptr);
                end
            end
        end
    end

    initial begin
        do_reset();
        mon_en = 1'b1;

        // Back-to-back frees into an idle ring.
        for (int i = 1; i <= 4; i++) step(1'b1, PTR_W'(i), 1'b0, '0, 1'b0);
        idle(3);

        // Pass-through, then a pointer freed under a busy, stalled ring.
        step(1'b0, '0, 1'b1, 14'h155, 1'b0);
        step(1'b1, 14'h03F, 1'b1, 14'h2AB, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b1);
        idle(3);

        // Ring busy with 3 queued: no pops, starvation at exactly 255.
        do_reset();
        for (int k = 1; k <= 260; k++) begin
            step(k <= 3, PTR_W'(16 + k), 1'b1, 14'h2AA, 1'b0);
            if (k == 255) chk("starve_254", {31'b0, pod_starve}, 32'd0);
            if (k == 256) chk("starve_255", {31'b0, pod_starve}, 32'd1);
        end
        chk("starve_held", {31'b0, pod_starve}, 32'd1);
        idle(1);
        chk("starve_cleared", {31'b0, pod_starve}, 32'd0);
        idle(3);

        // Fill under stall, high watermark, full, then drain in order.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            step(1'b1, PTR_W'(256 + k), 1'b0, '0, 1'b1);
            if (k == 10) chk("hi_at_11", {31'b0, pod_fifo_hi}, 32'd0);
            if (k == 11) chk("hi_at_12", {31'b0, pod_fifo_hi}, 32'd1);
        end
        chk("ready_full", {31'b0, pod_free_ready}, 32'd0);
        step(1'b1, 14'h1FF, 1'b0, '0, 1'b1);
        idle(18);
        chk("hi_drained", {31'b0, pod_fifo_hi}, 32'd0);

        // Push and pop every cycle at count 1, beyond one pointer wrap.
        for (int k = 0; k < 20; k++) step(1'b1, PTR_W'(512 + k), 1'b0, '0, 1'b0);
        idle(3);

        // Reset with 5 entries queued: nothing stale may reach the ring.
        for (int k = 0; k < 5; k++) step(1'b1, PTR_W'(768 + k), 1'b0, '0, 1'b1);
        reset_n = 1'b0;
        mq.delete();
        exp_q.delete();
        @(posedge cclk);
        #1;
        chk("midrst_out_valid", {31'b0, pod_ring_out_valid}, 32'd0);
        chk("midrst_ready", {31'b0, pod_free_ready}, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("midrst_ready_rel", {31'b0, pod_free_ready}, 32'd1);
        idle(10);

`ifdef MBY_POD_INJ_STATS_EN
        do_reset();
        step(1'b1, 14'h400, 1'b0, '0, 1'b1);
        for (int k = 0; k < 7; k++) step(1'b0, '0, 1'b0, '0, 1'b1);
        for (int k = 1; k <= 9; k++) step(1'b1, PTR_W'(1024 + k), 1'b0, '0, 1'b0);
        idle(3);
        chk("inj_cnt", pod_inj_cnt, 32'd10);
        chk("stall_cnt", pod_stall_cnt, 32'd7);
`endif

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge cclk);
        if (exp_q.size() != 0) begin
            vec++;
            errs++;
            $display("FAIL drain_timeout: got %0d pending slots, required 0", exp_q.size());
        end
        @(negedge cclk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
